ram_rr_arbiter: RTL and testbench

//  Two-requester round-robin arbiter that shares one single-port RAM (2**R words x 2**W bits).

---
 rtl/ram_rr_arbiter.sv | 89 ++++++++
 tb/tb_ram_rr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// Two-client round-robin arbiter in front of a single-port RAM with a 1-cycle registered read.
// One access is in flight at a time; read data is steered back to the client that issued it.
module ram_rr_arbiter #(
  parameter int R = 7,
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [R-1:0]      addr0,
  input  logic [2**W-1:0]   din0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [R-1:0]      addr1,
  input  logic [2**W-1:0]   din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [2**W-1:0]   rdata,
  output logic              ram_en,
  output logic              ram_wr_rd,
  output logic [R-1:0]      ram_addr,
  output logic [2**W-1:0]   ram_d_in,
  input  logic [2**W-1:0]   ram_d_out
);

  typedef enum logic [1:0] {IDLE, CMD, RD_WAIT} state_t;

  state_t state;
  logic   last;
  logic   win1;

  // On contention the client that was not served last wins; last also names the in-flight client.
  assign win1 = req1 && (!req0 || !last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      ram_en    <= 1'b0;
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_d_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= CMD;
            ram_en    <= 1'b1;
            gnt0      <= !win1;
            gnt1      <= win1;
            last      <= win1;
            ram_wr_rd <= win1 ? wr1 : wr0;
            ram_addr  <= win1 ? addr1 : addr0;
            ram_d_in  <= win1 ? din1 : din0;
          end
        end
        CMD: begin
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          ram_en <= 1'b0;
          if (ram_wr_rd) begin
            state <= IDLE;
          end else begin
            state   <= RD_WAIT;
            rvalid0 <= !last;
            rvalid1 <= last;
          end
        end
        RD_WAIT: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM output is already registered, so it is passed straight through while a read is returned.
  assign rdata = (rvalid0 || rvalid1) ? ram_d_out : '0;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: behavioural RAM, directed scenarios, and a randomized run
// checked against an edge-count model of the arbitration rules.
module tb_ram_rr_arbiter;
  localparam int R     = 7;
  localparam int W     = 4;
  localparam int DW    = 2**W;
  localparam int DEPTH = 2**R;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [R-1:0]  addr0 = '0, addr1 = '0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_wr_rd;
  logic [DW-1:0] rdata, ram_d_in, ram_d_out;
  logic [R-1:0]  ram_addr;
  logic [DW-1:0] ram_mem [DEPTH];
  int passed = 0;
  int total  = 0;

  ram_rr_arbiter #(.R(R), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .din0(din0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .din1(din1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr_rd) ram_mem[ram_addr] <= ram_d_in;
      else           ram_d_out <= ram_mem[ram_addr];
    end
  end

  task automatic drive(input int c, input logic r, input logic w, input logic [R-1:0] a,
                       input logic [DW-1:0] d);
    if (c == 0) begin req0 = r; wr0 = w; addr0 = a; din0 = d; end
    else begin req1 = r; wr1 = w; addr1 = a; din1 = d; end
  endtask

  // One access from an idle arbiter; returns grant latency (-1 on timeout) and read data.
  task automatic access(input int c, input logic w, input logic [R-1:0] a, input logic [DW-1:0] d,
                        output int glat, output logic [DW-1:0] q);
    glat = -1;
    q    = '0;
    drive(c, 1'b1, w, a, d);
    for (int i = 1; i <= 6 && glat < 0; i++) begin
      @(posedge clk); #1;
      if ((c == 0) ? gnt0 : gnt1) glat = i;
    end
    drive(c, 1'b0, w, a, d);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if ((c == 0) ? rvalid0 : rvalid1) q = rdata;
    end
  endtask

  task automatic test_reset();
    int en_seen;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {req0, wr0, req1, wr1} = 4'($urandom);
      addr0 = R'($urandom); addr1 = R'($urandom);
      din0 = DW'($urandom); din1 = DW'($urandom);
      @(posedge clk); #1;
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_wr_rd, ram_addr, ram_d_in, rdata} !== '0)
        $display("FAIL reset_outputs: got %h, expected 0",
                 {gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_wr_rd, ram_addr, ram_d_in, rdata});
      else passed++;
    end
    {req0, wr0, req1, wr1} = 4'b0;
    rst = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ram_en || gnt0 || gnt1) en_seen++;
    end
    total++;
    if (en_seen !== 0) $display("FAIL idle_quiet: activity cycles=%0d, expected 0", en_seen);
    else passed++;
  endtask

  task automatic test_wr_rd_client0();
    logic [5:0]    exp_ctl [5];
    logic [DW-1:0] exp_rd  [5];
    // {gnt0, gnt1, ram_en, ram_wr_rd, rvalid0, rvalid1} per cycle after the write request
    exp_ctl = '{6'b101100, 6'b000100, 6'b101000, 6'b000010, 6'b000000};
    exp_rd  = '{16'h0, 16'h0, 16'h0, 16'hA5A5, 16'h0};
    drive(0, 1'b1, 1'b1, 7'd5, 16'hA5A5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({gnt0, gnt1, ram_en, ram_wr_rd, rvalid0, rvalid1} !== exp_ctl[i])
        $display("FAIL wr_rd_ctl[%0d]: got %b, expected %b", i,
                 {gnt0, gnt1, ram_en, ram_wr_rd, rvalid0, rvalid1}, exp_ctl[i]);
      else passed++;
      total++;
      if (rdata !== exp_rd[i]) $display("FAIL wr_rd_data[%0d]: got %h, expected %h", i, rdata, exp_rd[i]);
      else passed++;
      if (i == 0) begin
        total++;
        if ({ram_addr, ram_d_in} !== {7'd5, 16'hA5A5})
          $display("FAIL wr_cmd: got addr=%0d din=%h, expected addr=5 din=a5a5", ram_addr, ram_d_in);
        else passed++;
      end
      if (i == 0 || i == 2) req0 = 1'b0;
      if (i == 1) drive(0, 1'b1, 1'b0, 7'd5, 16'hA5A5);
    end
  endtask

  task automatic test_simultaneous();
    int glat, ng, prev, first, cur;
    logic [DW-1:0] q;
    access(0, 1'b1, 7'd1, 16'h1111, glat, q);
    access(1, 1'b1, 7'd2, 16'h2222, glat, q);
    drive(0, 1'b1, 1'b0, 7'd1, '0);
    drive(1, 1'b1, 1'b0, 7'd2, '0);
    ng = 0; prev = -1; first = -1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      total++;
      if ((gnt0 & gnt1) !== 1'b0 || (rvalid0 & rvalid1) !== 1'b0)
        $display("FAIL sim_exclusive[%0d]: gnt=%b%b rvalid=%b%b", i, gnt0, gnt1, rvalid0, rvalid1);
      else passed++;
      if (gnt0 || gnt1) begin
        cur = gnt1 ? 1 : 0;
        if (first < 0) first = cur;
        else begin
          total++;
          if (cur == prev) $display("FAIL sim_alternate[%0d]: client %0d twice, expected %0d", i, cur, 1 - prev);
          else passed++;
        end
        prev = cur;
        ng++;
      end
      if (rvalid0) begin
        total++;
        if (rdata !== 16'h1111) $display("FAIL sim_rdata0: got %h, expected 1111", rdata);
        else passed++;
      end
      if (rvalid1) begin
        total++;
        if (rdata !== 16'h2222) $display("FAIL sim_rdata1: got %h, expected 2222", rdata);
        else passed++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    total++;
    if (first !== 0) $display("FAIL sim_first: got client %0d, expected 0", first);
    else passed++;
    total++;
    if (ng !== 8) $display("FAIL sim_count: got %0d grants, expected 8", ng);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int gcyc [4];
    int k, glat;
    logic [DW-1:0] q;
    k = 0;
    gcyc = '{0, 0, 0, 0};
    drive(1, 1'b1, 1'b1, 7'd0, 16'h3000);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      total++;
      if (gnt0 !== 1'b0) $display("FAIL stream_no_gnt0[%0d]: got 1, expected 0", i);
      else passed++;
      if (gnt1 && k < 4) begin
        gcyc[k] = i;
        k++;
        if (k < 4) drive(1, 1'b1, 1'b1, R'(k), DW'(16'h3000 + k));
        else req1 = 1'b0;
      end
    end
    total++;
    if (k !== 4) $display("FAIL stream_count: got %0d grants, expected 4", k);
    else passed++;
    for (int j = 1; j < 4; j++) begin
      total++;
      if (gcyc[j] - gcyc[j-1] !== 2)
        $display("FAIL stream_spacing[%0d]: got %0d cycles, expected 2", j, gcyc[j] - gcyc[j-1]);
      else passed++;
    end
    // Client 1 was served last, so client 0 takes the next tie
    drive(0, 1'b1, 1'b0, 7'd0, '0);
    drive(1, 1'b1, 1'b0, 7'd3, '0);
    @(posedge clk); #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL stream_priority: got gnt=%b%b, expected 10", gnt0, gnt1);
    else passed++;
    req0 = 1'b0;
    for (int i = 0; i < 6 && req1; i++) begin
      @(posedge clk); #1;
      if (gnt1) req1 = 1'b0;
    end
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      access(0, 1'b0, R'(j), '0, glat, q);
      total++;
      if (glat !== 1 || q !== DW'(16'h3000 + j))
        $display("FAIL stream_readback[%0d]: got lat=%0d data=%h, expected lat=1 data=%h", j, glat, q,
                 DW'(16'h3000 + j));
      else passed++;
    end
  endtask

  task automatic test_reset_rdwait();
    int rv_after;
    drive(0, 1'b1, 1'b0, 7'd3, '0);
    @(posedge clk); #1;
    total++;
    if (gnt0 !== 1'b1) $display("FAIL rstrd_gnt: got %b, expected 1", gnt0);
    else passed++;
    req0 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rvalid0 !== 1'b1 || rdata !== 16'h3003)
      $display("FAIL rstrd_rvalid: got rvalid0=%b rdata=%h, expected 1/3003", rvalid0, rdata);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (rvalid0 !== 1'b0 || rdata !== '0)
      $display("FAIL rstrd_abort: got rvalid0=%b rdata=%h, expected 0/0", rvalid0, rdata);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 7'd0, '0);
    drive(1, 1'b1, 1'b0, 7'd1, '0);
    @(posedge clk); #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) $display("FAIL rstrd_priority: got gnt=%b%b, expected 10", gnt0, gnt1);
    else passed++;
    req0 = 1'b0;
    rv_after = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (gnt1) req1 = 1'b0;
      if (rvalid0 && rdata !== 16'h3000) rv_after++;
    end
    req1 = 1'b0;
    total++;
    if (rv_after !== 0) $display("FAIL rstrd_stale: got %0d stale rvalid0, expected 0", rv_after);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int glat;
    logic [DW-1:0] q;
    access(0, 1'b1, 7'd127, 16'hBEEF, glat, q);
    total++;
    if (glat !== 1) $display("FAIL wrap_wr_hi: got lat=%0d, expected 1", glat);
    else passed++;
    access(1, 1'b1, 7'd0, 16'h1234, glat, q);
    access(1, 1'b0, 7'd127, '0, glat, q);
    total++;
    if (q !== 16'hBEEF) $display("FAIL wrap_rd_hi: got %h, expected beef", q);
    else passed++;
    access(0, 1'b0, 7'd0, '0, glat, q);
    total++;
    if (q !== 16'h1234) $display("FAIL wrap_rd_lo: got %h, expected 1234", q);
    else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [DEPTH];
    bit            written [DEPTH];
    int            free_e, rd_due, e, mlast, rd_cli, win;
    logic [DW-1:0] rd_val, e_din, e_rd;
    logic [R-1:0]  e_addr;
    logic          e_wr, ge0, ge1, erv0, erv1, een;
    bit            pend0, pend1;
    for (int i = 0; i < DEPTH; i++) begin written[i] = 1'b0; ref_mem[i] = '0; end
    {req0, req1} = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    free_e = 0; rd_due = -1; mlast = 1; rd_cli = 0; rd_val = '0;
    e_wr = 1'b0; e_addr = '0; e_din = '0;
    pend0 = 1'b0; pend1 = 1'b0;
    for (e = 0; e < 800; e++) begin
      @(posedge clk);
      ge0 = 1'b0; ge1 = 1'b0; erv0 = 1'b0; erv1 = 1'b0; een = 1'b0; e_rd = '0;
      if (rd_due == e) begin
        erv0 = (rd_cli == 0); erv1 = (rd_cli == 1); e_rd = rd_val;
      end
      if (e >= free_e && (req0 || req1)) begin
        if (req0 && req1) win = (mlast == 1) ? 0 : 1;
        else              win = req0 ? 0 : 1;
        mlast = win;
        ge0 = (win == 0); ge1 = (win == 1); een = 1'b1;
        e_wr   = win ? wr1 : wr0;
        e_addr = win ? addr1 : addr0;
        e_din  = win ? din1 : din0;
        if (e_wr) begin
          ref_mem[e_addr] = e_din;
          written[e_addr] = 1'b1;
          free_e = e + 2;
        end else begin
          rd_due = e + 1; rd_cli = win; rd_val = ref_mem[e_addr];
          free_e = e + 3;
        end
      end
      #1;
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_wr_rd, ram_addr, ram_d_in, rdata} !==
          {ge0, ge1, erv0, erv1, een, e_wr, e_addr, e_din, e_rd})
        $display("FAIL rand[%0d]: got g=%b%b rv=%b%b en=%b wr=%b a=%0d d=%h rd=%h, expected g=%b%b rv=%b%b en=%b wr=%b a=%0d d=%h rd=%h",
                 e, gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_wr_rd, ram_addr, ram_d_in, rdata,
                 ge0, ge1, erv0, erv1, een, e_wr, e_addr, e_din, e_rd);
      else passed++;
      if (ge0) pend0 = 1'b0;
      if (ge1) pend1 = 1'b0;
      if (!pend0 && $urandom_range(2) == 0) begin
        pend0 = 1'b1;
        wr0 = 1'($urandom_range(1)); addr0 = R'($urandom_range(15)); din0 = DW'($urandom);
        if (!wr0 && !written[addr0]) wr0 = 1'b1;
      end
      if (!pend1 && $urandom_range(2) == 0) begin
        pend1 = 1'b1;
        wr1 = 1'($urandom_range(1)); addr1 = R'($urandom_range(15)); din1 = DW'($urandom);
        if (!wr1 && !written[addr1]) wr1 = 1'b1;
      end
      req0 = pend0;
      req1 = pend1;
    end
    {req0, req1} = 2'b00;
  endtask

  initial begin
    test_reset();
    test_wr_rd_client0();
    test_simultaneous();
    test_stream();
    test_reset_rdwait();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
